// File: rtl/tqvp_hx2003_pulse_seq_if.sv
// Bus bundle for the pulse sequencer's TinyQV peripheral port.
// The CPU side uses the master modport and the peripheral uses the slave modport.
interface tqvp_hx2003_pulse_seq_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (output address, data_in, data_write_n, data_read_n,
                    input  data_out, data_ready);
    modport slave  (input  address, data_in, data_write_n, data_read_n,
                    output data_out, data_ready);
endinterface

// File: rtl/tqvp_hx2003_pulse_seq.sv
// TinyQV pulse-sequence transmitter: a FIFO of {level, duration} symbols is played out on uo_out[1].
// Build macro PULSE_SEQ_LOOP_EN enables frame replay using the CTRL loop count.
module tqvp_hx2003_pulse_seq #(
    parameter int DEPTH     = 8,
    parameter int DUR_W     = 14,
    parameter int CARRIER_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    output logic       user_interrupt,
    tqvp_hx2003_pulse_seq_if.slave bus
);
    // state   | meaning
    // ST_IDLE | tx = idle_level, FIFO accepts pushes
    // ST_LOAD | one cycle: snapshot FIFO window, load timers from first entry
    // ST_RUN  | symbols playing, duration counted in prescaler ticks
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [1:0]           state;
    logic                 idle_level, carrier_en, irq_en;
    logic [3:0]           prescale;
    logic [CARRIER_W-1:0] carrier_c;
    logic [DUR_W:0]       mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr, base;
    logic [FW-1:0]        fill, n_snap, idx, idx_nxt;
    logic [DUR_W-1:0]     dur_cnt;
    logic [15:0]          presc_cnt, presc_reload;
    logic [CARRIER_W-1:0] car_cnt;
    logic                 car_phase, tx, ovf_flag, done_flag;
    logic                 wr32, wr_ctrl, wr_car, wr_fifo, wr_stat;
    logic                 start_req, stop_req, busy, empty, full;
    logic                 push_ok, push_drop, tick, sym_end, last_sym, loop_more, finish;
    logic                 cur_lvl;
    logic [31:0]          rd_data;
`ifdef PULSE_SEQ_LOOP_EN
    logic [7:0]           loop_cnt, loops_left;
`endif

    assign wr32      = (bus.data_write_n == 2'b10);
    assign wr_ctrl   = wr32 && (bus.address == 6'h00);
    assign wr_car    = wr32 && (bus.address == 6'h04);
    assign wr_fifo   = wr32 && (bus.address == 6'h08);
    assign wr_stat   = wr32 && (bus.address == 6'h0C);
    assign start_req = wr_ctrl & bus.data_in[0];
    assign stop_req  = wr_ctrl & bus.data_in[1];

    assign busy      = (state != ST_IDLE);
    assign empty     = (fill == '0);
    assign full      = (fill == FILL_MAX);
    assign push_ok   = wr_fifo & ~full & ~busy;
    assign push_drop = wr_fifo & (full | busy);

    assign presc_reload = (16'd1 << prescale) - 16'd1;
    assign idx_nxt      = idx + FW'(1);
    assign cur_lvl      = mem[base + idx[AW-1:0]][DUR_W];
    assign tick         = (presc_cnt == 16'd0);
    assign sym_end      = (state == ST_RUN) && tick && (dur_cnt == '0);
    assign last_sym     = (idx_nxt == n_snap);
`ifdef PULSE_SEQ_LOOP_EN
    assign loop_more    = (loops_left != 8'd0);
`else
    assign loop_more    = 1'b0;
`endif
    // A stop arriving on the same edge as the final symbol end still wins: no done.
    assign finish       = sym_end & last_sym & ~loop_more & ~stop_req;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {bus.data_in[31], bus.data_in[DUR_W-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idle_level <= 1'b0;
            carrier_en <= 1'b0;
            irq_en     <= 1'b0;
            prescale   <= '0;
            carrier_c  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            base       <= '0;
            fill       <= '0;
            n_snap     <= '0;
            idx        <= '0;
            dur_cnt    <= '0;
            presc_cnt  <= '0;
            car_cnt    <= '0;
            car_phase  <= 1'b0;
            tx         <= 1'b0;
            ovf_flag   <= 1'b0;
            done_flag  <= 1'b0;
`ifdef PULSE_SEQ_LOOP_EN
            loop_cnt   <= '0;
            loops_left <= '0;
`endif
        end else begin
            if (wr_ctrl) begin
                idle_level <= bus.data_in[2];
                carrier_en <= bus.data_in[3];
                prescale   <= bus.data_in[7:4];
`ifdef PULSE_SEQ_LOOP_EN
                loop_cnt   <= bus.data_in[15:8];
`endif
                irq_en     <= bus.data_in[16];
            end
            if (wr_car)
                carrier_c <= bus.data_in[CARRIER_W-1:0];
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
                fill   <= fill + FW'(1);
            end

            if (wr_stat && bus.data_in[3]) ovf_flag <= 1'b0;
            else if (push_drop)            ovf_flag <= 1'b1;
            if (wr_stat && bus.data_in[4]) done_flag <= 1'b0;
            else if (finish)               done_flag <= 1'b1;

            if (state == ST_RUN && !stop_req)
                tx <= cur_lvl & (~carrier_en | car_phase);
            else
                tx <= idle_level;

            if (stop_req && busy) begin
                state  <= ST_IDLE;
                fill   <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                case (state)
                    ST_IDLE: if (start_req && !stop_req && !empty) state <= ST_LOAD;
                    ST_LOAD: begin
                        base      <= rd_ptr;
                        n_snap    <= fill;
                        idx       <= '0;
                        dur_cnt   <= mem[rd_ptr][DUR_W-1:0];
                        presc_cnt <= presc_reload;
                        car_cnt   <= carrier_c;
                        car_phase <= 1'b1;
`ifdef PULSE_SEQ_LOOP_EN
                        loops_left <= loop_cnt;
`endif
                        state     <= ST_RUN;
                    end
                    ST_RUN: begin
                        presc_cnt <= tick ? presc_reload : presc_cnt - 16'd1;
                        if (tick) dur_cnt <= dur_cnt - DUR_W'(1);
                        if (car_cnt == '0) begin
                            car_phase <= ~car_phase;
                            car_cnt   <= carrier_c;
                        end else begin
                            car_cnt   <= car_cnt - CARRIER_W'(1);
                        end
                        if (sym_end) begin
                            car_phase <= 1'b1;
                            car_cnt   <= carrier_c;
                            if (!last_sym) begin
                                idx     <= idx_nxt;
                                dur_cnt <= mem[base + idx_nxt[AW-1:0]][DUR_W-1:0];
                            end
`ifdef PULSE_SEQ_LOOP_EN
                            else if (loop_more) begin
                                loops_left <= loops_left - 8'd1;
                                idx        <= '0;
                                dur_cnt    <= mem[base][DUR_W-1:0];
                            end
`endif
                            else begin
                                rd_ptr <= base + n_snap[AW-1:0];
                                fill   <= fill - n_snap;
                                state  <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (bus.address)
            6'h00: begin
                rd_data[2]    = idle_level;
                rd_data[3]    = carrier_en;
                rd_data[7:4]  = prescale;
`ifdef PULSE_SEQ_LOOP_EN
                rd_data[15:8] = loop_cnt;
`endif
                rd_data[16]   = irq_en;
            end
            6'h04: rd_data[CARRIER_W-1:0] = carrier_c;
            6'h0C: begin
                rd_data[0]      = busy;
                rd_data[1]      = empty;
                rd_data[2]      = full;
                rd_data[3]      = ovf_flag;
                rd_data[4]      = done_flag;
                rd_data[8 +: FW] = fill;
            end
            default: ;
        endcase
    end

    assign bus.data_out    = rd_data;
    assign bus.data_ready  = 1'b1;
    assign uo_out          = {5'b0, busy, tx, 1'b0};
    assign user_interrupt  = done_flag & irq_en;

    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in, bus.data_read_n, bus.data_in};
endmodule

// File: tb/tb_tqvp_hx2003_pulse_seq.sv
// Scoreboard bench for the pulse sequencer: a reference model expands symbol lists into per-clock tx.
// Honours PULSE_SEQ_LOOP_EN when the build defines it.
module tb_tqvp_hx2003_pulse_seq;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic       user_interrupt;

    tqvp_hx2003_pulse_seq_if bus_if();

    tqvp_hx2003_pulse_seq #(.DEPTH(DEPTH), .DUR_W(14), .CARRIER_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .user_interrupt(user_interrupt), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        logic [95:0] nm;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  sym_lv[$];
    int  sym_d[$];
    bit  wave[$];

    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(input logic [95:0] nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", nm, got, exp, cyc);
        end
    endfunction

    // Monitor: compares every scoreboard entry that falls due on this cycle.
    always @(negedge clk) begin
        logic [31:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s stale entry for cycle %0d", sb[i].nm, sb[i].cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                case (sb[i].sel)
                    0:       got = {24'd0, uo_out};
                    1:       got = bus_if.data_out;
                    default: got = {31'd0, user_interrupt};
                endcase
                chk(sb[i].nm, got, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus_if.address = a;
        bus_if.data_in = d;
        bus_if.data_write_n = 2'b10;
        @(posedge clk); #1;
        bus_if.data_write_n = 2'b11;
    endtask

    task automatic expect_rd(input logic [5:0] a, input logic [31:0] e, input logic [95:0] nm);
        @(posedge clk); #1;
        bus_if.address = a;
        sb.push_back('{cyc, 1, e, nm});
    endtask

    task automatic expect_irq(input logic e, input logic [95:0] nm);
        @(posedge clk); #1;
        sb.push_back('{cyc, 2, {31'd0, e}, nm});
    endtask

    // Reference: each symbol spans (D+1)*2^P clocks; carrier is high for the first C+1 clocks of each 2(C+1).
    function automatic void build_wave(input bit ce, input int p, input int c, input int passes);
        wave.delete();
        for (int ps = 0; ps < passes; ps++)
            for (int s = 0; s < sym_lv.size(); s++)
                for (int t = 0; t < ((sym_d[s] + 1) << p); t++)
                    if (sym_lv[s] == 0)  wave.push_back(1'b0);
                    else if (!ce)        wave.push_back(1'b1);
                    else                 wave.push_back(((t / (c + 1)) % 2) == 0);
    endfunction

    task automatic run_seq(input bit il, input bit ce, input int p, input int c, input int l,
                           input bit ie, input logic [95:0] nm);
        logic [31:0] cfg, cfg_rd;
        int t, passes;
        cfg = {15'd0, ie, 8'(l), 4'(p), ce, il, 2'b00};
        cfg_rd = cfg;
`ifdef PULSE_SEQ_LOOP_EN
        passes = l + 1;
`else
        passes = 1;
        cfg_rd[15:8] = 8'd0;
`endif
        wr(6'h04, 32'(c));
        wr(6'h00, cfg);
        expect_rd(6'h00, cfg_rd, "ctrl_rd");
        expect_rd(6'h04, 32'(c), "carrier_rd");
        for (int s = 0; s < sym_lv.size(); s++)
            wr(6'h08, {sym_lv[s][0], 17'd0, 14'(sym_d[s])});
        build_wave(ce, p, c, passes);
        t = wave.size();
        wr(6'h00, cfg | 32'h1);
        for (int k = 0; k < t + 4; k++) begin
            bit tx_e, busy_e;
            busy_e = (k <= t);
            tx_e   = (k >= 2 && k <= t + 1) ? wave[k-2] : il;
            sb.push_back('{cyc + k, 0, {29'd0, busy_e, tx_e, 1'b0}, nm});
        end
        repeat (t + 4) @(posedge clk);
        expect_rd(6'h0C, 32'h012, "stat_done");
        expect_irq(ie, "irq_set");
        wr(6'h0C, 32'h10);
        expect_irq(1'b0, "irq_clr");
        expect_rd(6'h0C, 32'h002, "stat_clr");
        sym_lv.delete();
        sym_d.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout sim time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ui_in = 8'd0;
        bus_if.address = 6'h0C;
        bus_if.data_in = 32'd0;
        bus_if.data_write_n = 2'b11;
        bus_if.data_read_n = 2'b11;
        #1;
        chk("reset_uo", {24'd0, uo_out}, 32'h0);
        chk("reset_stat", bus_if.data_out, 32'h002);
        chk("reset_irq", {31'd0, user_interrupt}, 32'h0);
        chk("data_ready", {31'd0, bus_if.data_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // basic: high 4, low 2
        sym_lv = '{1, 0}; sym_d = '{3, 1};
        run_seq(1'b0, 1'b0, 0, 0, 0, 1'b0, "basic_tx");
        // carrier C=1
        sym_lv = '{1}; sym_d = '{7};
        run_seq(1'b0, 1'b1, 0, 1, 0, 1'b0, "carrier_tx");
        // loop count 2, irq enabled
        sym_lv = '{1, 0}; sym_d = '{0, 0};
        run_seq(1'b0, 1'b0, 0, 0, 2, 1'b1, "loop_tx");

        // overflow, push while busy, stop mid-run
        wr(6'h00, 32'h14);
        for (int i = 0; i < DEPTH + 1; i++) wr(6'h08, 32'd9);
        expect_rd(6'h0C, 32'h80C, "ovf_full");
        wr(6'h0C, 32'h8);
        expect_rd(6'h0C, 32'h804, "ovf_clr");
        wr(6'h00, 32'h15);
        repeat (6) @(posedge clk);
        expect_rd(6'h0C, 32'h805, "run_busy");
        wr(6'h08, 32'd3);
        expect_rd(6'h0C, 32'h80D, "busy_push");
        wr(6'h00, 32'h16);
        sb.push_back('{cyc + 1, 0, 32'h02, "stop_tx"});
        expect_rd(6'h0C, 32'h00A, "stop_stat");
        wr(6'h0C, 32'h8);

        // start on empty FIFO is ignored
        wr(6'h00, 32'h1);
        sb.push_back('{cyc + 1, 0, 32'h00, "empty_tx"});
        expect_rd(6'h0C, 32'h002, "empty_start");

        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int s = 0; s < n; s++) begin
                sym_lv.push_back($urandom_range(0, 1));
                sym_d.push_back($urandom_range(0, 5));
            end
            run_seq($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1), "rand_tx");
        end

        // async reset mid-run
        wr(6'h00, 32'h04);
        wr(6'h08, 32'd200);
        wr(6'h00, 32'h05);
        repeat (20) @(posedge clk);
        #1;
        bus_if.address = 6'h0C;
        chk("pre_rst_uo", {24'd0, uo_out}, 32'h04);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_uo", {24'd0, uo_out}, 32'h0);
        chk("arst_stat", bus_if.data_out, 32'h002);
        chk("arst_irq", {31'd0, user_interrupt}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_rd(6'h00, 32'h0, "arst_ctrl");
        repeat (3) @(posedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d entries exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
